// File: rtl/display_scan.sv
// display_scan: time-multiplexed digit scanner with double-buffered data, PWM brightness and blink mask
module display_scan #(
  parameter int SIZE       = 4,
  parameter int SEG_W      = 8,
  parameter int DIV_LOG2   = 10,
  parameter int BLINK_LOG2 = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [SIZE*SEG_W-1:0] i_data,
  input  logic                  i_load,
  input  logic [SIZE-1:0]       i_blink_mask,
  input  logic [3:0]            i_bright,
  output logic [SEG_W-1:0]      o_seg,
  output logic [SIZE-1:0]       o_dig,
  output logic                  o_frame,
  output logic                  o_ack
);
  localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
  logic [DIV_LOG2-1:0]   r_slot;
  logic [IW-1:0]         r_idx;
  logic [BLINK_LOG2-1:0] r_fcnt;
  logic [SIZE*SEG_W-1:0] r_stage, r_shadow;
  logic                  r_pend, r_frame, r_ack;
  logic [SEG_W-1:0]      r_seg;
  logic [SIZE-1:0]       r_dig;
  logic                  w_wrap, w_fend, w_on;
  assign w_wrap = &r_slot;
  assign w_fend = w_wrap && r_idx == IW'(SIZE - 1);
  // slot 0 is a guard blank so the previous digit's segments never ghost onto the next
  assign w_on = (|r_slot) && (r_slot[DIV_LOG2-1 -: 4] <= i_bright) &&
                !(r_fcnt[BLINK_LOG2-1] && i_blink_mask[r_idx]);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot   <= '0;
      r_idx    <= '0;
      r_fcnt   <= '0;
      r_stage  <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_frame  <= 1'b0;
      r_ack    <= 1'b0;
      r_seg    <= '0;
      r_dig    <= '0;
    end else begin
      r_slot <= r_slot + 1'b1;
      if (w_wrap) r_idx <= w_fend ? '0 : r_idx + 1'b1;
      if (w_fend) r_fcnt <= r_fcnt + 1'b1;
      if (i_load) r_stage <= i_data;
      if (w_fend && r_pend) r_shadow <= r_stage;
      r_pend  <= i_load | (r_pend & ~w_fend);
      r_frame <= w_fend;
      r_ack   <= w_fend & r_pend;
      r_dig   <= w_on ? SIZE'(1) << r_idx : '0;
      r_seg   <= w_on ? r_shadow[r_idx*SEG_W +: SEG_W] : '0;
    end
  end
  assign o_seg   = r_seg;
  assign o_dig   = r_dig;
  assign o_frame = r_frame;
  assign o_ack   = r_ack;
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: vector-table and directed-sequence checks of display_scan
module tb_display_scan;
  logic        clk = 0, rst = 1, load = 0;
  logic [31:0] data = '0;
  logic [3:0]  mask = '0, bright = 4'd15;
  logic [7:0]  seg, seg5;
  logic [3:0]  dig, dig5;
  logic        frame, ack, frame5, ack5;
  int tests = 0, fails = 0;
  int ecount = 0, ack_n = 0, frame_n = 0, first_frame = 0, last_ack = 0;

  display_scan #(.SIZE(4), .SEG_W(8), .DIV_LOG2(4), .BLINK_LOG2(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_load(load), .i_blink_mask(mask),
    .i_bright(bright), .o_seg(seg), .o_dig(dig), .o_frame(frame), .o_ack(ack));
  display_scan #(.SIZE(4), .SEG_W(8), .DIV_LOG2(5), .BLINK_LOG2(2)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_load(load), .i_blink_mask(mask),
    .i_bright(bright), .o_seg(seg5), .o_dig(dig5), .o_frame(frame5), .o_ack(ack5));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
    if (ack) begin ack_n++; last_ack = ecount; end
    if (frame) begin frame_n++; if (first_frame == 0) first_frame = ecount; end
  endtask

  task automatic run_to(input int n);
    while (ecount < n) tick();
  endtask

  task automatic do_reset();
    rst = 1;
    load = 0;
    repeat (3) tick();
    rst = 0;
    ecount = 0; ack_n = 0; frame_n = 0; first_frame = 0; last_ack = 0;
  endtask

  typedef struct {
    logic [3:0]      bright;
    logic [3:0]      mask;
    int              frame;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs [10];
  int   cnt [4];
  int   bad;

  initial begin
    vecs[0] = '{4'd15, 4'b0000, 0, {8'd15, 8'd15, 8'd15, 8'd15}};
    vecs[1] = '{4'd0,  4'b0000, 0, {8'd0,  8'd0,  8'd0,  8'd0 }};
    vecs[2] = '{4'd7,  4'b0000, 1, {8'd7,  8'd7,  8'd7,  8'd7 }};
    vecs[3] = '{4'd15, 4'b0010, 0, {8'd15, 8'd15, 8'd15, 8'd15}};
    vecs[4] = '{4'd15, 4'b0010, 1, {8'd15, 8'd15, 8'd15, 8'd15}};
    vecs[5] = '{4'd15, 4'b0010, 2, {8'd15, 8'd15, 8'd0,  8'd15}};
    vecs[6] = '{4'd15, 4'b0010, 3, {8'd15, 8'd15, 8'd0,  8'd15}};
    vecs[7] = '{4'd15, 4'b0010, 4, {8'd15, 8'd15, 8'd15, 8'd15}};
    vecs[8] = '{4'd15, 4'b0010, 6, {8'd15, 8'd15, 8'd0,  8'd15}};
    vecs[9] = '{4'd3,  4'b1001, 2, {8'd0,  8'd3,  8'd3,  8'd0 }};

    // reset and idle
    rst = 1;
    repeat (3) tick();
    chk("in_reset", {seg, dig, frame, ack}, 0);
    rst = 0;
    ecount = 0; ack_n = 0; frame_n = 0; first_frame = 0;
    tick();
    chk("edge1_blank", {seg, dig, frame, ack}, 0);
    tick();
    chk("edge2_dig0", dig, 4'b0001);
    run_to(70);
    chk("first_frame", first_frame, 64);

    // PWM and blink table
    for (int i = 0; i < 10; i++) begin
      bright = vecs[i].bright;
      mask = vecs[i].mask;
      do_reset();
      run_to(64 * vecs[i].frame);
      cnt = '{0, 0, 0, 0};
      bad = 0;
      repeat (64) begin
        tick();
        for (int d = 0; d < 4; d++) if (dig == 4'(1 << d)) cnt[d]++;
        if (!$onehot0(dig) || (dig == 0 && seg != 0)) bad++;
      end
      for (int d = 0; d < 4; d++) chk($sformatf("vec%0d_dig%0d_on", i, d), cnt[d], 32'(vecs[i].exp[d]));
      chk($sformatf("vec%0d_illegal", i), bad, 0);
    end
    mask = 0;

    // load and commit
    bright = 15;
    do_reset();
    run_to(9);
    data = 32'h0F_3C_F0_FF;
    load = 1;
    tick();
    load = 0;
    run_to(66);
    chk("commit_ack_n", ack_n, 1);
    chk("commit_ack_at", last_ack, 64);
    chk("commit_d0", {dig, seg}, {4'b0001, 8'hFF});
    run_to(114);
    chk("commit_d3", {dig, seg}, {4'b1000, 8'h0F});
    run_to(130);
    chk("commit_single_ack", ack_n, 1);

    // load coinciding with frame end
    do_reset();
    run_to(9);
    data = 32'h11223344;
    load = 1;
    tick();
    load = 0;
    run_to(63);
    data = 32'hAABBCCDD;
    load = 1;
    tick();
    load = 0;
    run_to(66);
    chk("fe_frame2_d0", seg, 8'h44);
    run_to(114);
    chk("fe_frame2_d3", seg, 8'h11);
    run_to(130);
    chk("fe_ack_n", ack_n, 2);
    chk("fe_ack_at", last_ack, 128);
    chk("fe_frame3_d0", seg, 8'hDD);

    // brightness change mid-slot
    do_reset();
    run_to(2);
    chk("br_on", dig, 4'b0001);
    bright = 0;
    tick();
    chk("br_off", dig, 4'b0000);
    bright = 15;
    tick();
    chk("br_back", dig, 4'b0001);

    // DIV_LOG2=5, lowest brightness gives a single lit cycle per slot
    bright = 0;
    do_reset();
    cnt = '{0, 0, 0, 0};
    repeat (128) begin
      tick();
      for (int d = 0; d < 4; d++) if (dig5 == 4'(1 << d)) cnt[d]++;
    end
    for (int d = 0; d < 4; d++) chk($sformatf("div5_dig%0d_on", d), cnt[d], 1);

    // asynchronous mid-frame reset with a pending load
    bright = 15;
    do_reset();
    run_to(9);
    data = 32'hDEADBEEF;
    load = 1;
    tick();
    load = 0;
    run_to(40);
    chk("mid_pre", dig, 4'b0100);
    #2 rst = 1;
    #1;
    chk("mid_async", {seg, dig, frame, ack}, 0);
    tick();
    tick();
    chk("mid_hold", {seg, dig, frame, ack}, 0);
    rst = 0;
    ecount = 0; ack_n = 0; frame_n = 0; first_frame = 0;
    run_to(70);
    chk("mid_no_ack", ack_n, 0);
    chk("mid_frame_n", frame_n, 1);
    chk("mid_shadow_clear", seg5 | seg, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
